// File: rtl/lii_mem_target.sv
// LII memory target: decodes request packets and services them against an internal single-port RAM.
// Read beats appear 2 cycles after each header/beat handshake and the write ack 1 cycle after the last beat; all responses hold until resp_tready.
module lii_mem_target #(
  parameter int AXI_AW    = 48,
  parameter int AXI_DW    = 8,
  parameter int LII_DW    = 256,
  parameter int MEM_DEPTH = 4096
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [LII_DW-1:0]   lii_req_tdata,
  input  logic [LII_DW/8-1:0] lii_req_tkeep,
  input  logic [LII_DW/8-1:0] lii_req_tstrb,
  input  logic                lii_req_tlast,
  input  logic [7:0]          lii_req_src,
  input  logic [7:0]          lii_req_dst,
  input  logic                lii_req_tvalid,
  output logic                lii_req_tready,
  output logic [LII_DW-1:0]   lii_resp_tdata,
  output logic [LII_DW/8-1:0] lii_resp_tkeep,
  output logic [LII_DW/8-1:0] lii_resp_tstrb,
  output logic                lii_resp_tlast,
  output logic [7:0]          lii_resp_src,
  output logic [7:0]          lii_resp_dst,
  output logic                lii_resp_tvalid,
  input  logic                lii_resp_tready,
  input  logic [7:0]          cfg_src
);

  localparam int WB     = AXI_DW / 8;
  localparam int KW     = LII_DW / 8;
  localparam int WBL    = (WB > 1) ? $clog2(WB) : 0;
  localparam int MAW    = $clog2(MEM_DEPTH);
  localparam int IW     = AXI_AW + 1;
  localparam int OP_HI  = LII_DW - 1;
  localparam int LEN_HI = LII_DW - 3;
  localparam int AD_HI  = LII_DW - 14;
  localparam int TAG_HI = LII_DW - 14 - AXI_AW;

  typedef enum logic [2:0] {
    S_HDR, S_WDATA, S_DRAIN, S_BRESP, S_RADDR, S_RDATA
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          len_q, len_d;
  logic [AXI_AW-1:0]   base_q, base_d;
  logic [7:0]          tag_q, tag_d;
  logic [7:0]          beat_q, beat_d;
  logic                err_q, err_d;
  logic                req_rdy_q, req_rdy_d;
  logic                resp_vld_q, resp_vld_d;
  logic                resp_last_q, resp_last_d;
  logic [LII_DW-1:0]   resp_dat_q, resp_dat_d;
  logic [KW-1:0]       resp_keep_q, resp_keep_d;
  logic [7:0]          resp_dst_q, resp_dst_d;
  logic [7:0]          resp_src_q;

  logic [AXI_DW-1:0]   mem [MEM_DEPTH];

  logic [1:0]          hdr_op;
  logic [7:0]          hdr_len;
  logic [AXI_AW-1:0]   hdr_addr;
  logic [7:0]          hdr_tag;
  logic                req_hs, resp_hs, ack_load, rd_en, mem_we;
  logic [IW-1:0]       cur_idx;
  logic                cur_oor;
  logic [MAW-1:0]      mem_addr;

  assign hdr_op   = lii_req_tdata[OP_HI -: 2];
  assign hdr_len  = lii_req_tdata[LEN_HI -: 8];
  assign hdr_addr = lii_req_tdata[AD_HI -: AXI_AW];
  assign hdr_tag  = lii_req_tdata[TAG_HI -: 8];

  assign req_hs   = lii_req_tvalid & req_rdy_q;
  assign resp_hs  = resp_vld_q & lii_resp_tready;
  // Index is one bit wider than the address so base+beat never wraps back into range.
  assign cur_idx  = {1'b0, base_q} + IW'(beat_q);
  assign cur_oor  = cur_idx >= IW'(MEM_DEPTH);
  assign mem_addr = cur_idx[MAW-1:0];

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    base_d      = base_q;
    tag_d       = tag_q;
    beat_d      = beat_q;
    err_d       = err_q;
    resp_vld_d  = resp_vld_q;
    resp_last_d = resp_last_q;
    resp_dat_d  = resp_dat_q;
    resp_keep_d = resp_keep_q;
    resp_dst_d  = resp_dst_q;
    ack_load    = 1'b0;
    rd_en       = 1'b0;
    mem_we      = 1'b0;

    case (state_q)
      S_HDR: begin
        if (req_hs) begin
          len_d      = hdr_len;
          base_d     = hdr_addr >> WBL;
          tag_d      = hdr_tag;
          resp_dst_d = lii_req_src;
          beat_d     = 8'd0;
          err_d      = 1'b0;
          if (hdr_op == 2'b00 && lii_req_tlast) begin
            state_d = S_RADDR;
          end else if (hdr_op == 2'b01 && !lii_req_tlast) begin
            state_d = S_WDATA;
          end else begin
            err_d = 1'b1;
            if (lii_req_tlast) begin
              state_d  = S_BRESP;
              ack_load = 1'b1;
            end else begin
              state_d = S_DRAIN;
            end
          end
        end
      end
      S_WDATA: begin
        if (req_hs) begin
          if (cur_oor) err_d = 1'b1;
          else         mem_we = rstn;
          if (beat_q == len_q) begin
            if (lii_req_tlast) begin
              state_d  = S_BRESP;
              ack_load = 1'b1;
            end else begin
              err_d   = 1'b1;
              state_d = S_DRAIN;
            end
          end else if (lii_req_tlast) begin
            err_d    = 1'b1;
            state_d  = S_BRESP;
            ack_load = 1'b1;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      S_DRAIN: begin
        if (req_hs && lii_req_tlast) begin
          state_d  = S_BRESP;
          ack_load = 1'b1;
        end
      end
      S_BRESP: begin
        if (resp_hs) begin
          state_d    = S_HDR;
          resp_vld_d = 1'b0;
        end
      end
      S_RADDR: begin
        rd_en                  = 1'b1;
        state_d                = S_RDATA;
        resp_vld_d             = 1'b1;
        resp_last_d            = (beat_q == len_q);
        resp_keep_d            = '0;
        resp_keep_d[WB-1:0]    = '1;
      end
      S_RDATA: begin
        if (resp_hs) begin
          resp_vld_d = 1'b0;
          if (resp_last_q) begin
            state_d = S_HDR;
          end else begin
            beat_d  = beat_q + 8'd1;
            state_d = S_RADDR;
          end
        end
      end
      default: state_d = S_HDR;
    endcase

    if (ack_load) begin
      resp_vld_d        = 1'b1;
      resp_last_d       = 1'b1;
      resp_keep_d       = '0;
      resp_dat_d        = '0;
      resp_dat_d[1:0]   = err_d ? 2'b10 : 2'b00;
      resp_dat_d[15:8]  = tag_d;
    end

    req_rdy_d = (state_d == S_HDR) || (state_d == S_WDATA) || (state_d == S_DRAIN);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= S_HDR;
      len_q       <= '0;
      base_q      <= '0;
      tag_q       <= '0;
      beat_q      <= '0;
      err_q       <= 1'b0;
      req_rdy_q   <= 1'b0;
      resp_vld_q  <= 1'b0;
      resp_last_q <= 1'b0;
      resp_dat_q  <= '0;
      resp_keep_q <= '0;
      resp_dst_q  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      base_q      <= base_d;
      tag_q       <= tag_d;
      beat_q      <= beat_d;
      err_q       <= err_d;
      req_rdy_q   <= req_rdy_d;
      resp_vld_q  <= resp_vld_d;
      resp_last_q <= resp_last_d;
      resp_keep_q <= resp_keep_d;
      resp_dst_q  <= resp_dst_d;
      // Synchronous RAM read lands straight in the response data register.
      if (rd_en)
        resp_dat_q <= {{(LII_DW-AXI_DW){1'b0}}, cur_oor ? {AXI_DW{1'b0}} : mem[mem_addr]};
      else
        resp_dat_q <= resp_dat_d;
    end
  end

  // RAM has no reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < WB; b++) begin
        if (lii_req_tstrb[b]) mem[mem_addr][8*b +: 8] <= lii_req_tdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    resp_src_q <= cfg_src;
  end

  logic unused_inputs;
  assign unused_inputs = ^{lii_req_dst, lii_req_tkeep, lii_req_tstrb, lii_req_tdata};

  assign lii_req_tready  = req_rdy_q;
  assign lii_resp_tdata  = resp_dat_q;
  assign lii_resp_tkeep  = resp_keep_q;
  assign lii_resp_tstrb  = resp_keep_q;
  assign lii_resp_tlast  = resp_last_q;
  assign lii_resp_src    = resp_src_q;
  assign lii_resp_dst    = resp_dst_q;
  assign lii_resp_tvalid = resp_vld_q;

endmodule
